// File: rtl/acumulador_3bits.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | acumulador_3bits: 3-bit accumulator that sequences an external adder via a |
// | 3-state handshake. Optional ACUMULADOR_SAT_EN clamps acc to 7 on carry.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module acumulador_3bits (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] b_in,
  input  logic       inc,
  input  logic       clear,
  output logic [2:0] op_a,
  output logic [2:0] op_b,
  output logic       cin_n,
  input  logic [2:0] sum_in,
  input  logic       cout_in,
  output logic [2:0] acc,
  output logic       ovf,
  output logic       done,
  output logic [3:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] acc_q, acc_d;
  logic [2:0] op_b_q, op_b_d;
  logic       cin_n_q, cin_n_d;
  logic       ovf_q, ovf_d;
  logic [3:0] count_q, count_d;
  logic [2:0] acc_load;

  always_comb begin
    acc_load = sum_in;
`ifdef ACUMULADOR_SAT_EN
    if (cout_in) begin
      acc_load = 3'd7;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_b_d  = op_b_q;
    cin_n_d = cin_n_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          acc_d   = 3'd0;
          ovf_d   = 1'b0;
          count_d = 4'd0;
        end else if (in_valid) begin
          op_b_d  = b_in;
          cin_n_d = ~inc;
          state_d = ADD;
        end
      end
      ADD: begin
        // The adder has had a full cycle to settle on op_a/op_b/cin_n.
        acc_d   = acc_load;
        ovf_d   = ovf_q | cout_in;
        count_d = (count_q == 4'd15) ? count_q : count_q + 4'd1;
        cin_n_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 3'd0;
      op_b_q  <= 3'd0;
      cin_n_q <= 1'b1;
      ovf_q   <= 1'b0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_b_q  <= op_b_d;
      cin_n_q <= cin_n_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign done     = (state_q == DONE);
  assign op_a     = acc_q;
  assign op_b     = op_b_q;
  assign cin_n    = cin_n_q;
  assign acc      = acc_q;
  assign ovf      = ovf_q;
  assign count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_acumulador_3bits.sv
`default_nettype none
// Testbench for acumulador_3bits: directed operations with an attached adder model
// and a done-driven scoreboard.
module tb_acumulador_3bits;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] b_in;
  logic       inc;
  logic       clear;
  logic [2:0] op_a;
  logic [2:0] op_b;
  logic       cin_n;
  logic [2:0] sum_in;
  logic       cout_in;
  logic [2:0] acc;
  logic       ovf;
  logic       done;
  logic [3:0] count;

`ifdef ACUMULADOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    logic [2:0] acc;
    logic       ovf;
    logic [3:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Downstream 3-bit adder with active-low carry-in.
  logic [3:0] add_full;
  assign add_full = {1'b0, op_a} + {1'b0, op_b} + {3'b000, ~cin_n};
  assign sum_in   = add_full[2:0];
  assign cout_in  = add_full[3];

  acumulador_3bits dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .b_in     (b_in),
    .inc      (inc),
    .clear    (clear),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin_n    (cin_n),
    .sum_in   (sum_in),
    .cout_in  (cout_in),
    .acc      (acc),
    .ovf      (ovf),
    .done     (done),
    .count    (count)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("acc", int'(acc), int'(e.acc));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("count", int'(count), int'(e.cnt));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_op(input logic [2:0] b, input logic inc_v,
                       input logic [2:0] e_acc, input logic e_ovf, input logic [3:0] e_cnt);
    exp_t e;
    wait_ready();
    e.acc = e_acc;
    e.ovf = e_ovf;
    e.cnt = e_cnt;
    q.push_back(e);
    in_valid = 1'b1;
    b_in     = b;
    inc      = inc_v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    inc      = 1'b0;
    chk("add_op_b", int'(op_b), int'(b));
    chk("add_cin_n", int'(cin_n), int'(!inc_v));
    chk("add_ready", int'(in_ready), 0);
  endtask

  task automatic do_clear();
    wait_ready();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    int acc_cyc[3];
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    b_in     = 3'd0;
    inc      = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_acc", int'(acc), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_op_b", int'(op_b), 0);
    chk("rst_cin_n", int'(cin_n), 1);
    chk("rst_ready", int'(in_ready), 1);
    chk("rst_done", int'(done), 0);

    // Basic adds, including the carry-in path: 0+3, then 3+2+1.
    do_op(3'd3, 1'b0, 3'd3, 1'b0, 4'd1);
    do_op(3'd2, 1'b1, 3'd6, 1'b0, 4'd2);

    // Overflow: 6+1=7, 7+1 wraps (or saturates), ovf stays sticky.
    do_op(3'd1, 1'b0, 3'd7, 1'b0, 4'd3);
    do_op(3'd1, 1'b0, SAT ? 3'd7 : 3'd0, 1'b1, 4'd4);
    do_op(3'd0, 1'b0, SAT ? 3'd7 : 3'd0, 1'b1, 4'd5);
    do_op(3'd3, 1'b0, SAT ? 3'd7 : 3'd3, 1'b1, 4'd6);
    wait_ready();
    chk("idle_cin_n", int'(cin_n), 1);
    chk("idle_op_b_hold", int'(op_b), 3);

    // Clear beats a simultaneous operand.
    do_clear();
    do_op(3'd5, 1'b0, 3'd5, 1'b0, 4'd1);
    wait_ready();
    clear    = 1'b1;
    in_valid = 1'b1;
    b_in     = 3'd2;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clr_acc", int'(acc), 0);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_count", int'(count), 0);
    chk("clr_stay_idle", int'(in_ready), 1);

    // in_valid held high: acceptances 3 cycles apart.
    for (int i = 1; i <= 3; i++) begin
      exp_t e;
      e.acc = 3'(i);
      e.ovf = 1'b0;
      e.cnt = 4'(i);
      q.push_back(e);
    end
    in_valid = 1'b1;
    b_in     = 3'd1;
    n = 0;
    for (int c = 0; c < 30 && n < 3; c++) begin
      @(negedge clk);
      if (in_ready) begin
        acc_cyc[n] = c;
        n++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("stream_accepts", n, 3);
    if (n == 3) begin
      chk("stream_gap1", acc_cyc[1] - acc_cyc[0], 3);
      chk("stream_gap2", acc_cyc[2] - acc_cyc[1], 3);
    end

    // Reset during ADD aborts the operation.
    do_op(3'd1, 1'b0, 3'd4, 1'b0, 4'd4);
    wait_ready();
    in_valid = 1'b1;
    b_in     = 3'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_done", int'(done), 0);
    end
    chk("abort_acc", int'(acc), 0);
    chk("abort_count", int'(count), 0);

    // Count saturation with zero operands.
    for (int i = 1; i <= 16; i++) begin
      do_op(3'd0, 1'b0, 3'd0, 1'b0, (i > 15) ? 4'd15 : 4'(i));
    end
    wait_ready();
    repeat (3) @(posedge clk);
    #1;
    chk("sat_count", int'(count), 15);
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
